// File: rtl/seg7_capture_if.sv
// Result handshake bundle of seg7_capture.
// err_count is present only with SEG7_CAP_STATS_EN.
interface seg7_capture_if;
  logic [4:0] val_out;
  logic       err;
  logic       out_valid;
  logic       out_ready;
`ifdef SEG7_CAP_STATS_EN
  logic [7:0] err_count;

  modport master (
    output val_out,
    output err,
    output out_valid,
    output err_count,
    input  out_ready
  );

  modport slave (
    input  val_out,
    input  err,
    input  out_valid,
    input  err_count,
    output out_ready
  );
`else
  modport master (
    output val_out,
    output err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  val_out,
    input  err,
    input  out_valid,
    output out_ready
  );
`endif
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment readback: waits for stable digits, decodes value.
// SEG7_CAP_STATS_EN adds a saturating illegal-result counter.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           con,
  input  logic [6:0]     hex_in,
  input  logic [6:0]     hex1_in,
  seg7_capture_if.master res
);

  typedef enum logic [1:0] {
    SETTLE,
    PRESENT,
    DONE
  } state_t;

  localparam logic [6:0]  BLANK = 7'h7f;
  localparam logic [14:0] IDLE  = {1'b0, BLANK, BLANK};
  localparam logic [CNT_W:0] THR = STABLE_CYCLES[CNT_W:0];

  state_t          st;
  state_t          st_n;
  logic [14:0]     samp;
  logic [14:0]     cap;
  logic [14:0]     cap_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W:0]  run_n;
  logic [4:0]      val_q;
  logic [4:0]      val_n;
  logic            err_q;
  logic            err_n;
  logic            load;
  logic [5:0]      dec;

  // {ok, digit}; ok=0 for blank or anything the decoder never drives
  function automatic logic [4:0] glyph(input logic [6:0] p);
    logic [4:0] r;
    r = 5'd0;
    unique case (1'b1)
      (p == 7'b1000000): r = 5'h10;
      (p == 7'b1111001): r = 5'h11;
      (p == 7'b0100100): r = 5'h12;
      (p == 7'b0110000): r = 5'h13;
      (p == 7'b0011001): r = 5'h14;
      (p == 7'b0010010): r = 5'h15;
      (p == 7'b0000010): r = 5'h16;
      (p == 7'b1111000): r = 5'h17;
      (p == 7'b0000000): r = 5'h18;
      (p == 7'b0010000): r = 5'h19;
      (p == 7'b0001000): r = 5'h1a;
      (p == 7'b0000011): r = 5'h1b;
      (p == 7'b1000110): r = 5'h1c;
      (p == 7'b0100001): r = 5'h1d;
      (p == 7'b0000110): r = 5'h1e;
      (p == 7'b0001110): r = 5'h1f;
      default:           r = 5'h00;
    endcase
    return r;
  endfunction

  // {err, val}
  function automatic logic [5:0] decode(input logic [14:0] s);
    logic [4:0] g0;
    logic [4:0] g1;
    logic [3:0] one;
    logic [1:0] ten;
    logic [5:0] v;
    logic       bad;
    g1  = glyph(s[13:7]);
    g0  = glyph(s[6:0]);
    bad = !g0[4];
    one = g0[3:0];
    ten = 2'd0;
    if (s[13:7] != BLANK) begin
      if (g1[4] && g1[3:0] >= 4'd1 && g1[3:0] <= 4'd3)
        ten = g1[1:0];
      else
        bad = 1'b1;
    end
    if (s[14]) begin
      if (ten > 2'd1) bad = 1'b1;
      v = {1'b0, ten[0], one};
    end else begin
      if (one > 4'd9) bad = 1'b1;
      v = {1'b0, ten, 3'b000}
        + {3'b000, ten, 1'b0}
        + {2'b00, one};
      if (v > 6'd31) bad = 1'b1;
    end
    if (bad) return {1'b1, 5'd0};
    return {1'b0, v[4:0]};
  endfunction

  assign dec = decode(samp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= DONE;
      samp  <= IDLE;
      cap   <= IDLE;
      cnt   <= '0;
      val_q <= 5'd0;
      err_q <= 1'b0;
    end else begin
      st    <= st_n;
      samp  <= {con, hex1_in, hex_in};
      cap   <= cap_n;
      cnt   <= cnt_n;
      val_q <= val_n;
      err_q <= err_n;
    end
  end

  // run_n is the number of identical samples held, this one included
  always_comb begin
    st_n  = st;
    cap_n = cap;
    cnt_n = cnt;
    val_n = val_q;
    err_n = err_q;
    run_n = '0;
    load  = 1'b0;
    unique case (st)
      SETTLE: begin
        cap_n = samp;
        if (samp == cap) cnt_n = cnt + 1'b1;
        else             cnt_n = '0;
        run_n = {1'b0, cnt_n} + 1'b1;
        load  = (run_n >= THR);
      end
      PRESENT: begin
        if (res.out_ready) st_n = DONE;
      end
      DONE: begin
        if (samp != cap) begin
          cap_n = samp;
          cnt_n = '0;
          run_n = {{CNT_W{1'b0}}, 1'b1};
          load  = (run_n >= THR);
          if (!load) st_n = SETTLE;
        end
      end
      default: st_n = DONE;
    endcase
    if (load) begin
      st_n  = PRESENT;
      cap_n = samp;
      err_n = dec[5];
      val_n = dec[4:0];
    end
  end

  assign res.out_valid = (st == PRESENT);
  assign res.val_out   = val_q;
  assign res.err       = err_q;

`ifdef SEG7_CAP_STATS_EN
  logic [7:0] ecnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= 8'd0;
    end else if (st == PRESENT && res.out_ready
                 && err_q && ecnt != 8'hff) begin
      ecnt <= ecnt + 8'd1;
    end
  end

  assign res.err_count = ecnt;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed cases
// plus random digit pairs against a table-driven model.
module tb_seg7_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] BL = 7'h7f;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       con = 1'b0;
  logic [6:0] hex_in = BL;
  logic [6:0] hex1_in = BL;

  int vectors = 0;
  int miscompares = 0;
  int nerr = 0;

  logic [6:0] gl [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_capture_if ifc ();

  seg7_capture #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .con(con),
    .hex_in(hex_in),
    .hex1_in(hex1_in),
    .res(ifc.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {err, val} from the display rules
  function automatic logic [5:0] ref_dec(input logic c,
                                         input logic [6:0] t,
                                         input logic [6:0] o);
    int oi;
    int ti;
    int v;
    oi = -1;
    ti = -1;
    for (int i = 0; i < 16; i++) if (gl[i] == o) oi = i;
    if (t == BL) ti = 0;
    else for (int i = 1; i < 4; i++) if (gl[i] == t) ti = i;
    if (oi < 0 || ti < 0) return 6'h20;
    if (c) begin
      if (ti > 1) return 6'h20;
      v = ti * 16 + oi;
    end else begin
      if (oi > 9) return 6'h20;
      v = ti * 10 + oi;
      if (v > 31) return 6'h20;
    end
    return {1'b0, v[4:0]};
  endfunction

  task automatic drive(input logic c, input logic [6:0] t,
                       input logic [6:0] o);
    con = c;
    hex1_in = t;
    hex_in = o;
  endtask

  // edges from (and including) the capture edge until out_valid
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ifc.out_valid === 1'b1) break;
    end
  endtask

  task automatic ack();
    if (ifc.err === 1'b1) nerr++;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk("valid_drop", ifc.out_valid, 0);
  endtask

  task automatic present(input string tag, input logic c,
                         input logic [6:0] t, input logic [6:0] o);
    int n;
    logic [5:0] e;
    e = ref_dec(c, t, o);
    drive(c, t, o);
    wait_valid(n);
    chk({tag, "_lat"}, n, STABLE + 1);
    chk({tag, "_err"}, ifc.err, e[5]);
    chk({tag, "_val"}, ifc.val_out, e[4:0]);
    ack();
  endtask

  initial begin
    int n;
    int hi;
    logic [14:0] last;
    logic [14:0] nx;
    logic c;
    logic [6:0] t;
    logic [6:0] o;
    int v;

    ifc.out_ready = 1'b0;
    drive(1'b1, gl[1], gl[15]);
    #12;
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_val", ifc.val_out, 0);
    chk("rst_err", ifc.err, 0);
`ifdef SEG7_CAP_STATS_EN
    chk("rst_ecnt", ifc.err_count, 0);
`endif
    // ready held high from reset release
    ifc.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk("first_lat", n, 5);
    chk("first_val", ifc.val_out, 31);
    chk("first_err", ifc.err, 0);
    hi = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.out_valid) hi++;
    end
    chk("single_pulse", hi, 0);
    ifc.out_ready = 1'b0;

    present("dec31", 1'b0, gl[3], gl[1]);
    present("dec32", 1'b0, gl[3], gl[2]);
    present("decA", 1'b0, BL, gl[10]);
    present("hexA", 1'b1, BL, gl[10]);

    // toggle every two cycles: never stable long enough
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, BL, (i % 2) ? gl[2] : gl[1]);
      repeat (2) begin
        @(posedge clk);
        @(negedge clk);
        if (ifc.out_valid) hi++;
      end
    end
    chk("glitch_none", hi, 0);
    present("glitch_end", 1'b0, BL, gl[7]);

    // backpressure while the display moves on
    drive(1'b0, BL, gl[5]);
    wait_valid(n);
    chk("bp_lat", n, STABLE + 1);
    chk("bp_val", ifc.val_out, 5);
    drive(1'b0, BL, gl[9]);
    hi = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.out_valid !== 1'b1 || ifc.val_out !== 5'd5) hi++;
    end
    chk("bp_hold", hi, 0);
    ack();
    wait_valid(n);
    chk("bp_relat", n, STABLE);
    chk("bp_val9", ifc.val_out, 9);
    chk("bp_err9", ifc.err, 0);
    ack();

    last = {1'b0, BL, gl[9]};
    for (int k = 0; k < 10; k++) begin
      nx = last;
      while (nx == last) begin
        c = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) begin
          v = $urandom_range(0, 31);
          if (c) begin
            t = (v >= 16) ? gl[1] : BL;
            o = gl[v % 16];
          end else begin
            t = (v >= 10) ? gl[v / 10] : BL;
            o = gl[v % 10];
          end
        end else begin
          o = 7'($urandom);
          t = ($urandom_range(0, 1) != 0) ? BL
                : gl[$urandom_range(0, 15)];
        end
        nx = {c, t, o};
      end
      present("rand", nx[14], nx[13:7], nx[6:0]);
      last = nx;
    end

    // async reset while a result is pending
    drive(1'b1, gl[1], gl[3]);
    wait_valid(n);
    chk("pre_rst_val", ifc.val_out, 19);
    #2;
    rst_n = 1'b0;
    drive(1'b0, BL, BL);
    #1;
    chk("rst_async", ifc.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.out_valid) hi++;
    end
    chk("rst_noreport", hi, 0);
    present("post_rst", 1'b0, gl[2], gl[8]);

`ifdef SEG7_CAP_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stat_clr", ifc.err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    present("stat_e1", 1'b0, BL, gl[11]);
    present("stat_e2", 1'b1, gl[2], gl[0]);
    present("stat_e3", 1'b0, gl[0], gl[5]);
    present("stat_ok", 1'b0, BL, gl[4]);
    chk("stat_cnt", ifc.err_count, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
